// File: rtl/seg7_scan_mux.sv
// Multiplexed seven-segment scanner: dwell-timed digit scan, PWM dimming, tear-free frame loads.
// Optional macro LEADING_ZERO_BLANK_EN blanks leading zero digits.
module seg7_scan_mux #(
  parameter int NUM_DIGITS = 4,
  parameter int SCAN_DIV   = 50000,
  parameter int BRIGHT_W   = 3
) (
  input  logic                    FPGA_CLK,
  input  logic                    RESET_BUT,
  input  logic [4*NUM_DIGITS-1:0] data,
  input  logic [NUM_DIGITS-1:0]   dots,
  input  logic [NUM_DIGITS-1:0]   digit_mask,
  input  logic                    load,
  input  logic [BRIGHT_W-1:0]     brightness,
  output logic [6:0]              segment,
  output logic                    dot,
  output logic [NUM_DIGITS-1:0]   seg_enable_num,
  output logic                    frame_start
);

  localparam int CW = $clog2(SCAN_DIV);
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int MW = CW + BRIGHT_W + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(SCAN_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIGITS - 1);
  localparam logic [MW-1:0] DIV_M    = MW'(SCAN_DIV);

  logic [CW-1:0]           cnt_q, cnt_d;
  logic [IW-1:0]           idx_q, idx_d;
  logic [4*NUM_DIGITS-1:0] pend_data_q, pend_data_d, act_data_q, act_data_d;
  logic [NUM_DIGITS-1:0]   pend_dots_q, pend_dots_d, act_dots_q, act_dots_d;
  logic [NUM_DIGITS-1:0]   pend_mask_q, pend_mask_d, act_mask_q, act_mask_d;
  logic                    pend_vld_q, pend_vld_d;
  logic [6:0]              seg_q, seg_d;
  logic                    dot_q, dot_d;
  logic [NUM_DIGITS-1:0]   en_q, en_d;
  logic                    fs_q, fs_d;

  logic                    wrap, boundary, on_phase, show;
  logic [3:0]              nib;
  logic                    dot_bit, mask_bit, lz_bit;
  logic [NUM_DIGITS-1:0]   lz_ok;
  logic [MW-1:0]           pwm_lhs, pwm_rhs;

  function automatic logic [6:0] hex2seg(input logic [3:0] v);
    case (v)
      4'h0: hex2seg = 7'h01;  4'h1: hex2seg = 7'h4F;
      4'h2: hex2seg = 7'h12;  4'h3: hex2seg = 7'h06;
      4'h4: hex2seg = 7'h4C;  4'h5: hex2seg = 7'h24;
      4'h6: hex2seg = 7'h20;  4'h7: hex2seg = 7'h0F;
      4'h8: hex2seg = 7'h00;  4'h9: hex2seg = 7'h04;
      4'hA: hex2seg = 7'h08;  4'hB: hex2seg = 7'h60;
      4'hC: hex2seg = 7'h31;  4'hD: hex2seg = 7'h42;
      4'hE: hex2seg = 7'h30;  default: hex2seg = 7'h38;
    endcase
  endfunction

  always_comb begin
    wrap     = (cnt_q == CNT_LAST);
    boundary = wrap && (idx_q == IDX_LAST);
    cnt_d    = wrap ? '0 : cnt_q + CW'(1);
    idx_d    = idx_q;
    if (wrap) idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IW'(1);

    pend_data_d = pend_data_q;
    pend_dots_d = pend_dots_q;
    pend_mask_d = pend_mask_q;
    pend_vld_d  = pend_vld_q;
    act_data_d  = act_data_q;
    act_dots_d  = act_dots_q;
    act_mask_d  = act_mask_q;
    // A load landing on the boundary itself bypasses the pending stage.
    if (boundary) begin
      pend_vld_d = 1'b0;
      if (load) begin
        act_data_d = data;
        act_dots_d = dots;
        act_mask_d = digit_mask;
      end else if (pend_vld_q) begin
        act_data_d = pend_data_q;
        act_dots_d = pend_dots_q;
        act_mask_d = pend_mask_q;
      end
    end else if (load) begin
      pend_data_d = data;
      pend_dots_d = dots;
      pend_mask_d = digit_mask;
      pend_vld_d  = 1'b1;
    end
  end

`ifdef LEADING_ZERO_BLANK_EN
  logic zero_above;
  always_comb begin
    lz_ok      = '1;
    zero_above = 1'b1;
    for (int unsigned k = 0; k < NUM_DIGITS - 1; k++) begin
      zero_above = zero_above & (act_data_q[4*(NUM_DIGITS-1-k) +: 4] == 4'h0);
      lz_ok[NUM_DIGITS-1-k] = ~zero_above;
    end
  end
`else
  always_comb lz_ok = '1;
`endif

  always_comb begin
    nib      = '0;
    dot_bit  = 1'b0;
    mask_bit = 1'b0;
    lz_bit   = 1'b0;
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      if (idx_q == IW'(i)) begin
        nib      = act_data_q[4*i +: 4];
        dot_bit  = act_dots_q[i];
        mask_bit = act_mask_q[i];
        lz_bit   = lz_ok[i];
      end
    end
    pwm_lhs  = MW'({cnt_q, {BRIGHT_W{1'b0}}});
    pwm_rhs  = (MW'(brightness) + MW'(1)) * DIV_M;
    // Excluding the wrap cycle forces the anti-ghost gap even at full scale.
    on_phase = (pwm_lhs < pwm_rhs) && !wrap;
    show     = on_phase && mask_bit && lz_bit;

    seg_d = 7'h7F;
    dot_d = 1'b1;
    en_d  = '1;
    if (show) begin
      seg_d = hex2seg(nib);
      dot_d = ~dot_bit;
      for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
        if (idx_q == IW'(i)) en_d[i] = 1'b0;
      end
    end
    fs_d = (cnt_q == '0) && (idx_q == '0);
  end

  always_ff @(posedge FPGA_CLK) begin
    if (!RESET_BUT) begin
      cnt_q       <= '0;
      idx_q       <= '0;
      pend_data_q <= '0;
      pend_dots_q <= '0;
      pend_mask_q <= '0;
      pend_vld_q  <= 1'b0;
      act_data_q  <= '0;
      act_dots_q  <= '0;
      act_mask_q  <= '0;
      seg_q       <= 7'h7F;
      dot_q       <= 1'b1;
      en_q        <= '1;
      fs_q        <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      pend_data_q <= pend_data_d;
      pend_dots_q <= pend_dots_d;
      pend_mask_q <= pend_mask_d;
      pend_vld_q  <= pend_vld_d;
      act_data_q  <= act_data_d;
      act_dots_q  <= act_dots_d;
      act_mask_q  <= act_mask_d;
      seg_q       <= seg_d;
      dot_q       <= dot_d;
      en_q        <= en_d;
      fs_q        <= fs_d;
    end
  end

  assign segment        = seg_q;
  assign dot            = dot_q;
  assign seg_enable_num = en_q;
  assign frame_start    = fs_q;

endmodule
